// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding a one-entry decode buffer.
// Latency: request accept -> instr_valid = memory latency + 1 cycle.
// Backpressure: no request is issued while the buffer is full, so every response is capturable.
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic            req_fire;
    logic            capture;
    logic [XLEN-1:0] redirect_tgt;

    // Gated by rst_n so no request leaks out while reset is held.
    assign imem_req_valid = rst_n && (state == REQ) && !instr_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign capture        = (state == WAIT) && imem_resp_valid && !redirect_valid;
    assign redirect_tgt   = redirect_pc & ~XLEN'(3);

    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (redirect_valid) begin
                    state_nxt = req_fire ? DROP : REQ;
                end else if (req_fire) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    state_nxt = imem_resp_err ? HALT : REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_nxt = REQ;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect wins over capture and increment; the stale buffer entry is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= '0;
            instr_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_tgt;
            instr_valid <= 1'b0;
        end else if (capture) begin
            instr_valid <= 1'b1;
            instr_pc    <= pc;
            instr_fault <= imem_resp_err;
            instr       <= imem_resp_err ? 32'h0 : imem_resp_data;
            if (!imem_resp_err) begin
                pc <= pc + XLEN'(4);
            end
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, grant budget, and an output scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_fault;

    fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_fault     (instr_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] req_log[$];
    int          hs_cycle[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          req_budget = 0;
    int          mem_lat = 1;
    logic [63:0] err_addr = '1;
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          cnt = 0;

    assign imem_req_ready = (req_budget > 0);

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory: samples accepts at negedge, updates response/budget at posedge+1.
    initial begin
        logic acc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (pend) begin
                    errors++;
                    $display("FAIL two_outstanding: request %h accepted while %h pending, required none", imem_req_addr, pend_addr);
                end
                acc = 1'b1;
                pend = 1'b1;
                pend_addr = imem_req_addr;
                cnt = mem_lat;
                req_log.push_back(imem_req_addr);
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (acc) req_budget--;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_addr);
                    imem_resp_err   = (pend_addr == err_addr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard: every decode handshake must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: got pc=%h instr=%h fault=%b, required no instruction", instr_pc, instr, instr_fault);
                end else begin
                    e = sb.pop_front();
                    hs_cycle.push_back(cycle);
                    if (instr_pc !== e.pc || instr !== e.ins || instr_fault !== e.fault) begin
                        errors++;
                        $display("FAIL instr_out: got pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
                                 instr_pc, instr, instr_fault, e.pc, e.ins, e.fault);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [63:0] a, input logic fault);
        exp_t e;
        e.pc    = a;
        e.ins   = fault ? 32'h0 : mem_word(a);
        e.fault = fault;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((sb.size() != 0 || pend || instr_valid) && n < max) begin
            step();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s_timeout: %0d entries left after %0d cycles, required 0", name, sb.size(), max);
        end
    endtask

    task automatic do_redirect(input logic [63:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        while (!pend && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (!pend) begin
            errors++;
            $display("FAIL %s_accept: no accepted request after 30 cycles, required one", name);
        end
    endtask

    task automatic test_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: req_valid=%b instr_valid=%b, required 0 0", imem_req_valid, instr_valid);
        end
        checks++;
        if (instr !== 32'h0 || instr_pc !== 64'h0 || instr_fault !== 1'b0 || imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_regs: instr=%h pc=%h fault=%b addr=%h, required all 0", instr, instr_pc, instr_fault, imem_req_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL first_req: valid=%b addr=%h, required 1 0000000000000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        step();
        mem_lat = 1;
        req_log.delete();
        hs_cycle.delete();
        for (int i = 0; i < 3; i++) push_exp(64'(i * 4), 1'b0);
        req_budget = 3;
        drain("seq", 40);
        checks++;
        if (req_log.size() != 3) begin
            errors++;
            $display("FAIL seq_req_count: got %0d requests, required 3", req_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (req_log[i] !== 64'(i * 4)) begin
                    errors++;
                    $display("FAIL seq_req_addr: request %0d addr=%h, required %h", i, req_log[i], 64'(i * 4));
                end
            end
        end
        checks++;
        if (hs_cycle.size() != 3 || hs_cycle[1] - hs_cycle[0] != 3 || hs_cycle[2] - hs_cycle[1] != 3) begin
            errors++;
            $display("FAIL seq_spacing: %0d handshakes, required 3 spaced by 3 cycles", hs_cycle.size());
        end
    endtask

    task automatic test_stall();
        int n = 0;
        instr_ready = 1'b0;
        push_exp(64'hC, 1'b0);
        req_budget = 1;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL stall_timeout: instr_valid=0 after 20 cycles, required 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr !== mem_word(64'hC) || instr_pc !== 64'hC || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: instr=%h pc=%h req_valid=%b, required %h 000000000000000c 0",
                         instr, instr_pc, imem_req_valid, mem_word(64'hC));
            end
        end
        step();
        instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10) begin
            errors++;
            $display("FAIL stall_resume: req_valid=%b addr=%h, required 1 0000000000000010", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_fault();
        step();
        err_addr = 64'h10;
        mem_lat  = 1;
        push_exp(64'h10, 1'b1);
        req_budget = 1;
        drain("fault", 20);
        req_budget = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_no_req: req_valid=%b addr=%h, required 0", imem_req_valid, imem_req_addr);
            end
        end
        step();
        req_budget = 0;
        do_redirect(64'h20);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h20) begin
            errors++;
            $display("FAIL halt_redirect: req_valid=%b addr=%h, required 1 0000000000000020", imem_req_valid, imem_req_addr);
        end
        err_addr = '1;
        push_exp(64'h20, 1'b0);
        req_budget = 1;
        drain("after_fault", 20);
    endtask

    task automatic test_drop();
        int n = 0;
        step();
        do_redirect(64'h8);
        mem_lat = 4;
        req_budget = 1;
        wait_accept("drop");
        do_redirect(64'h1002);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_state: req_valid=%b addr=%h, required 0 while response pending", imem_req_valid, imem_req_addr);
        end
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
            errors++;
            $display("FAIL drop_next_addr: req_valid=%b addr=%h, required 1 0000000000001000", imem_req_valid, imem_req_addr);
        end
        mem_lat = 1;
        push_exp(64'h1000, 1'b0);
        req_budget = 1;
        drain("drop", 20);
    endtask

    task automatic test_redirect_resp();
        int n = 0;
        step();
        mem_lat = 3;
        req_budget = 1;
        wait_accept("redir_resp");
        while (!imem_resp_valid && n < 10) begin
            step();
            n++;
        end
        do_redirect(64'h2000);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_resp: req_valid=%b addr=%h instr_valid=%b, required 1 0000000000002000 0",
                     imem_req_valid, imem_req_addr, instr_valid);
        end
        mem_lat = 1;
        push_exp(64'h2000, 1'b0);
        req_budget = 1;
        drain("redir_resp", 20);
    endtask

    task automatic test_wrap();
        step();
        do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        push_exp(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        req_budget = 1;
        drain("wrap", 20);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap_addr: req_valid=%b addr=%h, required 1 0000000000000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_flush();
        int n = 0;
        step();
        instr_ready = 1'b0;
        req_budget = 1;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        do_redirect(64'h43);
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h40) begin
            errors++;
            $display("FAIL redir_flush: instr_valid=%b req_valid=%b addr=%h, required 0 1 0000000000000040",
                     instr_valid, imem_req_valid, imem_req_addr);
        end
        instr_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        step();
        mem_lat = 5;
        req_budget = 1;
        wait_accept("reset_mid");
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_req_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: req_valid=%b instr_valid=%b addr=%h, required 0 0 0",
                     imem_req_valid, instr_valid, imem_req_addr);
        end
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after: req_valid=%b addr=%h instr_valid=%b, required 1 0 0",
                         imem_req_valid, imem_req_addr, instr_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_fault();
        test_drop();
        test_redirect_resp();
        test_wrap();
        test_redirect_flush();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries unconsumed, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 64, address/PC width; RESET_PC, default 64'h0, first fetch address.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  XLEN  fetch address (current PC).
REQ-007 imem_resp_valid  input  1  response valid for the single outstanding request; no backpressure.
REQ-008 imem_resp_data  input  32  instruction word.
REQ-009 imem_resp_err  input  1  access fault, qualified by imem_resp_valid.
REQ-010 redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 redirect_pc  input  XLEN  redirect target.
REQ-012 instr_valid  output  1  instruction to decode stage valid.
REQ-013 instr_ready  input  1  decode stage accepts.
REQ-014 instr  output  32  instruction word; opcode in instr[6:0].
REQ-015 instr_pc  output  XLEN  PC of instr.
REQ-016 instr_fault  output  1  instr carries an access fault; instr SHALL be 32'h0 when set.

Function
REQ-017 FSM states SHALL be REQ, WAIT, DROP, HALT.
REQ-018 imem_req_valid SHALL be (state==REQ) && !instr_valid, driven from registers only; imem_req_addr SHALL equal pc.
REQ-019 REQ: on imem_req_valid && imem_req_ready -> WAIT; otherwise stay.
REQ-020 WAIT: on imem_resp_valid with err=0, capture instr=data, instr_pc=pc, instr_fault=0, instr_valid=1, pc<=pc+4 (mod 2^XLEN), -> REQ.
REQ-021 WAIT: on imem_resp_valid with err=1, capture instr=0, instr_pc=pc, instr_fault=1, instr_valid=1, pc unchanged, -> HALT.
REQ-022 DROP: on imem_resp_valid discard response (no output change) -> REQ.
REQ-023 HALT: no requests issued; leave only on redirect.
REQ-024 Output buffer SHALL be one entry; instr_valid SHALL clear the cycle after instr_valid && instr_ready; instr/instr_pc/instr_fault SHALL hold while instr_valid && !instr_ready.
REQ-025 At most one request SHALL be outstanding; a request SHALL be issued only with an empty output buffer, so a response is always capturable.
REQ-026 Minimum throughput with 1-cycle memory and instr_ready=1: one instruction per 3 cycles; latency request accept -> instr_valid = memory latency + 1 cycle.
REQ-027 Redirect (any state) SHALL set pc<=redirect_pc with bits [1:0] forced to 0, and clear instr_valid next cycle, whether or not instr_ready is high.
REQ-028 Redirect next state: WAIT -> DROP; REQ with request accepted same cycle -> DROP; REQ not accepted -> REQ; DROP -> DROP, or REQ if imem_resp_valid same cycle; HALT -> REQ; WAIT with imem_resp_valid same cycle -> REQ, response discarded.
REQ-029 Redirect SHALL take priority over response capture and PC increment in the same cycle.
REQ-030 imem_req_addr SHALL change while imem_req_valid is high and unaccepted only due to redirect.

Reset
REQ-031 While rst_n=0: state=REQ, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_fault=0, imem_req_valid=0.
REQ-032 Reset mid-transaction SHALL abandon outstanding request; memory model is reset by the same rst_n.
REQ-033 First request SHALL assert in the first cycle after rst_n deasserts, addr=RESET_PC.

Verification
REQ-034 Reset release, 1-cycle memory, instr_ready=1 -> requests at 0x0, 0x4, 0x8; instr_pc 0x0, 0x4, 0x8 in order, every 3 cycles.
REQ-035 instr_ready=0 for 5 cycles with instr_valid=1 -> instr/instr_pc stable, imem_req_valid=0 throughout; resumes one cycle after ready.
REQ-036 redirect_pc=0x1002 while WAIT on 0x8 -> response for 0x8 dropped, never on instr; next request addr 0x1000.
REQ-037 imem_resp_err=1 on fetch of 0x10 -> instr_valid, instr_fault=1, instr=0, instr_pc=0x10; no further requests until redirect to 0x20, then request 0x20.
REQ-038 pc=2^XLEN-4 fetched -> next request addr 0x0.
REQ-039 redirect and imem_resp_valid same cycle in WAIT -> response discarded, state REQ, next addr = redirect target.
